// File: rtl/ycbcr_centroid_tracker_pkg.sv
// Shared widths, FSM states and the colour-window test for the centroid tracker.
package ycbcr_centroid_tracker_pkg;

  localparam int COORD_W = 10;
  localparam int COUNT_W = 19;
  localparam int SUM_W   = 28;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    DIV_X   = 3'd2,
    DIV_Y   = 3'd3,
    PUBLISH = 3'd4
  } state_t;

  // All window bounds are inclusive and unsigned; Y has only a lower bound.
  function automatic logic pixel_match(
    input logic [7:0] y,
    input logic [7:0] cb,
    input logic [7:0] cr,
    input logic [7:0] y_min,
    input logic [7:0] cb_min,
    input logic [7:0] cb_max,
    input logic [7:0] cr_min,
    input logic [7:0] cr_max
  );
    return (y >= y_min) && (cb >= cb_min) && (cb <= cb_max) &&
           (cr >= cr_min) && (cr <= cr_max);
  endfunction

endpackage

// File: rtl/ycbcr_centroid_tracker_seq_divider.sv
// Restoring divider, one quotient bit per cycle, SUM_W cycles per division.
// Handshake: start is taken only while busy is low; done pulses one cycle after the
// last quotient bit, and quotient holds its value until the next accepted start.
module seq_divider
  import ycbcr_centroid_tracker_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SUM_W-1:0]   dividend,
  input  logic [COUNT_W-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] quotient
);

  localparam logic [4:0] ITER_LAST = 5'(SUM_W - 1);

  logic [COUNT_W-1:0] rem, rem_src, rem_next, div_q, div_src;
  logic [SUM_W-1:0]   quo, quo_src, quo_next;
  logic [COUNT_W:0]   shifted;
  logic [4:0]         cnt;
  logic               start_go, q_bit;

  assign start_go = start && !busy;
  assign quotient = quo[COORD_W-1:0];

  // The start edge already performs the first iteration straight from the inputs.
  always_comb begin
    rem_src  = start_go ? '0 : rem;
    quo_src  = start_go ? dividend : quo;
    div_src  = start_go ? divisor : div_q;
    shifted  = {rem_src, quo_src[SUM_W-1]};
    q_bit    = (shifted >= {1'b0, div_src});
    rem_next = q_bit ? (shifted[COUNT_W-1:0] - div_src) : shifted[COUNT_W-1:0];
    quo_next = {quo_src[SUM_W-2:0], q_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      div_q <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_go) begin
        rem   <= rem_next;
        quo   <= quo_next;
        div_q <= divisor;
        cnt   <= ITER_LAST;
        busy  <= 1'b1;
      end else if (busy) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ycbcr_centroid_tracker.sv
// Per-frame centroid of pixels inside a YCbCr colour window, with a per-pixel match flag.
module ycbcr_centroid_tracker
  import ycbcr_centroid_tracker_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MIN_COUNT = 64
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iFRAME_START,
  input  logic               iVALID,
  input  logic [7:0]         iY,
  input  logic [7:0]         iCb,
  input  logic [7:0]         iCr,
  input  logic [7:0]         iY_MIN,
  input  logic [7:0]         iCB_MIN,
  input  logic [7:0]         iCB_MAX,
  input  logic [7:0]         iCR_MIN,
  input  logic [7:0]         iCR_MAX,
  output logic               oMATCH,
  output logic [COORD_W-1:0] oX_POS,
  output logic [COORD_W-1:0] oY_POS,
  output logic               oFOUND,
  output logic               oDONE,
  output state_t             dbg_state
);

  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(V_ACTIVE - 1);
  localparam logic [COUNT_W-1:0] MIN_CNT  = COUNT_W'(MIN_COUNT);

  state_t             state, state_next;
  logic [COORD_W-1:0] col, row, x_q, pos_y_new, div_quotient;
  logic [COUNT_W-1:0] count;
  logic [SUM_W-1:0]   sum_x, sum_y;
  logic pix_match, found_now;
  logic frame_clear, accept, div_start, div_sel_y, latch_x, publish;
  logic div_busy, div_done;

  assign pix_match = pixel_match(iY, iCb, iCr, iY_MIN, iCB_MIN, iCB_MAX, iCR_MIN, iCR_MAX);
  assign found_now = (count >= MIN_CNT);
  assign pos_y_new = (count == '0) ? '0 : div_quotient;
  assign dbg_state = state;

  seq_divider u_div (
    .clk      (iCLK),
    .rst      (iRST),
    .start    (div_start),
    .dividend (div_sel_y ? sum_y : sum_x),
    .divisor  (count),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= state_next;
  end

  // Y's division is started in the same cycle X's done arrives, so no cycle is lost between them.
  always_comb begin
    state_next  = state;
    frame_clear = 1'b0;
    accept      = 1'b0;
    div_start   = 1'b0;
    div_sel_y   = 1'b0;
    latch_x     = 1'b0;
    publish     = 1'b0;
    case (state)
      IDLE: begin
        if (iFRAME_START) begin
          frame_clear = 1'b1;
          state_next  = ACCUM;
        end
      end
      ACCUM: begin
        if (iFRAME_START) begin
          frame_clear = 1'b1;
        end else if (iVALID) begin
          accept = 1'b1;
          if (col == LAST_COL && row == LAST_ROW) state_next = DIV_X;
        end
      end
      DIV_X: begin
        if (count == '0) begin
          publish    = 1'b1;
          state_next = PUBLISH;
        end else if (div_done) begin
          latch_x    = 1'b1;
          div_start  = 1'b1;
          div_sel_y  = 1'b1;
          state_next = DIV_Y;
        end else if (!div_busy) begin
          div_start = 1'b1;
        end
      end
      DIV_Y: begin
        div_sel_y = 1'b1;
        if (div_done) begin
          publish    = 1'b1;
          state_next = PUBLISH;
        end
      end
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col    <= '0;
      row    <= '0;
      count  <= '0;
      sum_x  <= '0;
      sum_y  <= '0;
      x_q    <= '0;
      oMATCH <= 1'b0;
      oX_POS <= '0;
      oY_POS <= '0;
      oFOUND <= 1'b0;
      oDONE  <= 1'b0;
    end else begin
      oMATCH <= iVALID && pix_match;
      oDONE  <= publish;
      if (frame_clear) begin
        col   <= '0;
        row   <= '0;
        count <= '0;
        sum_x <= '0;
        sum_y <= '0;
        x_q   <= '0;
      end else if (accept) begin
        if (pix_match) begin
          count <= count + COUNT_W'(1);
          sum_x <= sum_x + SUM_W'(col);
          sum_y <= sum_y + SUM_W'(row);
        end
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + COORD_W'(1);
        end else begin
          col <= col + COORD_W'(1);
        end
      end
      if (latch_x) x_q <= div_quotient;
      // Positions only move on a successful detection; a miss keeps the last good fix.
      if (publish) begin
        oFOUND <= found_now;
        if (found_now) begin
          oX_POS <= x_q;
          oY_POS <= pos_y_new;
        end
      end
    end
  end

endmodule

// File: doc/ycbcr_centroid_tracker.md
YCBCR_CENTROID_TRACKER -- requirements
Module: ycbcr_centroid_tracker

Interface
REQ-001: Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002: Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003: Parameter MIN_COUNT, default 64, minimum matching pixels for a valid detection.
REQ-004: iCLK  input  1  pixel clock; all logic on the rising edge.
REQ-005: iRST  input  1  reset, asynchronous, active-high.
REQ-006: iFRAME_START  input  1  one-cycle pulse before the first active pixel of a frame.
REQ-007: iVALID  input  1  an active pixel is present on iY/iCb/iCr this cycle.
REQ-008: iY, iCb, iCr  input  8 each  pixel from the upstream RGB-to-YCbCr converter.
REQ-009: iY_MIN, iCB_MIN, iCB_MAX, iCR_MIN, iCR_MAX  input  8 each  colour window, sampled every cycle.
REQ-010: oMATCH  output  1  registered per-pixel match flag for overlay.
REQ-011: oX_POS  output  10  centroid column.
REQ-012: oY_POS  output  10  centroid row.
REQ-013: oFOUND  output  1  last completed frame met MIN_COUNT.
REQ-014: oDONE  output  1  one-cycle pulse when oX_POS/oY_POS/oFOUND update.

Function
REQ-015: A pixel matches iff iY>=iY_MIN, iCB_MIN<=iCb<=iCB_MAX, and iCR_MIN<=iCr<=iCR_MAX (all bounds inclusive, unsigned).
REQ-016: oMATCH equals the match result of the pixel sampled one cycle earlier when iVALID was 1, and is 0 otherwise.
REQ-017: Internal column counter (10 bit) and row counter (10 bit) clear on iFRAME_START; column increments on each accepted pixel and wraps at H_ACTIVE-1 to 0 while incrementing the row.
REQ-018: States: IDLE, ACCUM, DIV_X, DIV_Y, PUBLISH.
REQ-019: IDLE->ACCUM on iFRAME_START; accumulators (count 19 bit, sumX 28 bit, sumY 28 bit) clear on that same edge.
REQ-020: In ACCUM, each accepted matching pixel adds 1 to count, the current column to sumX, and the current row to sumY.
REQ-021: ACCUM->DIV_X on the edge that accepts pixel (H_ACTIVE-1, V_ACTIVE-1).
REQ-022: iFRAME_START in ACCUM restarts the frame: counters and accumulators clear; state stays ACCUM.
REQ-023: iVALID and iFRAME_START are ignored in DIV_X, DIV_Y, and PUBLISH; that frame is dropped and tracking resumes at the next iFRAME_START after return to IDLE.
REQ-024: DIV_X computes floor(sumX/count), and DIV_Y computes floor(sumY/count), each with a restoring divider at one quotient bit per cycle (28 cycles).
REQ-025: If count is 0, division is skipped, and the state goes DIV_X->PUBLISH on the next edge.
REQ-026: PUBLISH lasts one cycle: oDONE=1; oFOUND=(count>=MIN_COUNT); oX_POS/oY_POS load the quotients (low 10 bits) only when oFOUND becomes 1, otherwise they hold their previous values; next state is IDLE.
REQ-027: Latency with count>0: oDONE is high during the 58th cycle after the edge that accepts the last pixel.
REQ-028: Latency with count=0: oDONE is high during the 2nd cycle after that edge.
REQ-029: oFOUND, oX_POS, and oY_POS are stable between oDONE pulses.

Reset
REQ-030: iRST asserted forces state IDLE and clears every output (oMATCH, oX_POS, oY_POS, oFOUND, oDONE = 0), all counters, and all accumulators asynchronously.
REQ-031: Reset asserted mid-ACCUM or mid-divide discards the frame; no oDONE is produced for it.
REQ-032: After deassertion, nothing is accumulated until the next iFRAME_START.

Structure
REQ-033: A shared package holds the state enumeration and the width constants (COORD_W=10, COUNT_W=19, SUM_W=28).
REQ-034: The divider is one sub-module, seq_divider (start/busy/done handshake, SUM_W dividend, COUNT_W divisor), reused sequentially for X then Y.

Verification
REQ-035: Scenario 1: H_ACTIVE=8, V_ACTIVE=4, MIN_COUNT=1, all pixels match -> count 32, oX_POS=3, oY_POS=1, oFOUND=1, oDONE 58 cycles after the last pixel.
REQ-036: Scenario 2: same size, single matching pixel at (5,2) -> oX_POS=5, oY_POS=2, oFOUND=1.
REQ-037: Scenario 3: no matching pixels after scenario 2 -> oDONE 2 cycles after the last pixel, oFOUND=0, oX_POS=5 and oY_POS=2 held.
REQ-038: Scenario 4: MIN_COUNT=4, three matches -> oFOUND=0, positions held.
REQ-039: Scenario 5: boundary thresholds with iCb=iCB_MIN and iCr=iCR_MAX -> match; iCb=iCB_MIN-1 -> no match; oMATCH checked one cycle later.
REQ-040: Scenario 6: iFRAME_START mid-frame after 10 pixels, then iRST pulsed during DIV_Y of a later frame -> the first restart yields a result from the new frame only; after the reset no oDONE occurs and all outputs are 0.
